// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - data-first arbiter sharing one memory port between instruction and data buses
// Optional macro ARB_TIMEOUT_EN: aborts stalled transfers with oBusErr and 32'hDEADBEEF read data.
module mem_bus_arbiter #(
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iIReq,
  input  logic        iIWe,
  input  logic [3:0]  iIBe,
  input  logic [31:0] iIAddr,
  input  logic [31:0] iIWdata,
  output logic        oIAck,
  output logic [31:0] oIRdata,
  input  logic        iDReq,
  input  logic        iDWe,
  input  logic [3:0]  iDBe,
  input  logic [31:0] iDAddr,
  input  logic [31:0] iDWdata,
  output logic        oDAck,
  output logic [31:0] oDRdata,
  output logic        oMReq,
  output logic        oMWe,
  output logic [3:0]  oMBe,
  output logic [31:0] oMAddr,
  output logic [31:0] oMWdata,
  input  logic        iMAck,
  input  logic [31:0] iMRdata,
  output logic [1:0]  oOwner,
  output logic        oBusErr
);

  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic          runEn;
  logic [BW-1:0] burstCnt;
  logic          burstFull;
  logic          grantD;
  logic          grantI;

  if (MAX_D_BURST < 1 || TIMEOUT < 1) begin : gBadParam
    $error("mem_bus_arbiter: MAX_D_BURST and TIMEOUT must both be at least 1");
  end

  // Data wins unless it has already taken MAX_D_BURST grants in a row while instruction waits
  assign burstFull = (burstCnt == BURST_MAX);
  assign grantD    = iDReq && !(iIReq && burstFull);
  assign grantI    = iIReq && !grantD;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmoCnt;
`else
  assign oBusErr = 1'b0;
`endif

  // Arbitration is held off for one edge after reset release so the first grant sees settled inputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      runEn <= 1'b0;
    end else begin
      runEn <= 1'b1;
    end
  end

  // Arbiter FSM: grant in IDLE, hold the memory request in BUSY, one-cycle ack pulse in RESP
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      burstCnt <= '0;
      oMReq    <= 1'b0;
      oMWe     <= 1'b0;
      oMBe     <= '0;
      oMAddr   <= '0;
      oMWdata  <= '0;
      oOwner   <= 2'b00;
      oIAck    <= 1'b0;
      oDAck    <= 1'b0;
      oIRdata  <= '0;
      oDRdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      tmoCnt   <= '0;
      oBusErr  <= 1'b0;
`endif
    end else begin
      oIAck <= 1'b0;
      oDAck <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      oBusErr <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (runEn) begin
            if (!iIReq) begin
              burstCnt <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            tmoCnt <= '0;
`endif
            if (grantD) begin
              oMReq   <= 1'b1;
              oMWe    <= iDWe;
              oMBe    <= iDBe;
              oMAddr  <= iDAddr;
              oMWdata <= iDWdata;
              oOwner  <= 2'b10;
              state   <= BUSY;
              if (iIReq && !burstFull) begin
                burstCnt <= burstCnt + 1'b1;
              end
            end else if (grantI) begin
              oMReq    <= 1'b1;
              oMWe     <= iIWe;
              oMBe     <= iIBe;
              oMAddr   <= iIAddr;
              oMWdata  <= iIWdata;
              oOwner   <= 2'b01;
              burstCnt <= '0;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (iMAck) begin
            oMReq <= 1'b0;
            state <= RESP;
            if (oOwner == 2'b01) begin
              oIAck <= 1'b1;
              if (!oMWe) begin
                oIRdata <= iMRdata;
              end
            end else begin
              oDAck <= 1'b1;
              if (!oMWe) begin
                oDRdata <= iMRdata;
              end
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmoCnt == TMO_LAST) begin
            oMReq   <= 1'b0;
            oBusErr <= 1'b1;
            state   <= RESP;
            if (oOwner == 2'b01) begin
              oIAck   <= 1'b1;
              oIRdata <= 32'hDEADBEEF;
            end else begin
              oDAck   <= 1'b1;
              oDRdata <= 32'hDEADBEEF;
            end
          end else begin
            tmoCnt <= tmoCnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state  <= IDLE;
          oOwner <= 2'b00;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter against a queue-based model
module tb_mem_bus_arbiter;

  localparam int MAXB = 4;
  localparam int TMO  = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iIReq, iIWe, iDReq, iDWe, iMAck;
  logic [3:0]  iIBe, iDBe;
  logic [31:0] iIAddr, iIWdata, iDAddr, iDWdata, iMRdata;
  logic        oIAck, oDAck, oMReq, oMWe, oBusErr;
  logic [31:0] oIRdata, oDRdata, oMAddr, oMWdata;
  logic [3:0]  oMBe;
  logic [1:0]  oOwner;

  mem_bus_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iIReq(iIReq), .iIWe(iIWe), .iIBe(iIBe), .iIAddr(iIAddr), .iIWdata(iIWdata),
    .oIAck(oIAck), .oIRdata(oIRdata),
    .iDReq(iDReq), .iDWe(iDWe), .iDBe(iDBe), .iDAddr(iDAddr), .iDWdata(iDWdata),
    .oDAck(oDAck), .oDRdata(oDRdata),
    .oMReq(oMReq), .oMWe(oMWe), .oMBe(oMBe), .oMAddr(oMAddr), .oMWdata(oMWdata),
    .iMAck(iMAck), .iMRdata(iMRdata), .oOwner(oOwner), .oBusErr(oBusErr)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } job_t;

  job_t        qI[$];
  job_t        qD[$];
  logic [1:0]  expOwner[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastI = '0;
  logic [31:0] lastD = '0;
  bit          useForce = 1'b0;
  logic [31:0] forceRd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic job_t rndJob();
    job_t j;
    j.we    = 1'($urandom_range(0, 1));
    j.be    = 4'($urandom_range(1, 15));
    j.addr  = $urandom;
    j.wdata = $urandom;
    return j;
  endfunction

  // Requesters present their queue heads and keep them stable until the matching ack
  task automatic present();
    if (qI.size() > 0) begin
      iIReq = 1'b1; iIWe = qI[0].we; iIBe = qI[0].be; iIAddr = qI[0].addr; iIWdata = qI[0].wdata;
    end else begin
      iIReq = 1'b0; iIWe = 1'b0; iIBe = 4'h0; iIAddr = $urandom; iIWdata = $urandom;
    end
    if (qD.size() > 0) begin
      iDReq = 1'b1; iDWe = qD[0].we; iDBe = qD[0].be; iDAddr = qD[0].addr; iDWdata = qD[0].wdata;
    end else begin
      iDReq = 1'b0; iDWe = 1'b0; iDBe = 4'h0; iDAddr = $urandom; iDWdata = $urandom;
    end
  endtask

  // Expected grant order from the priority rule: data first, instruction after MAXB data grants in a row
  function automatic void buildOrder();
    int ni  = qI.size();
    int nd  = qD.size();
    int run = 0;
    expOwner.delete();
    while (ni > 0 || nd > 0) begin
      if (nd > 0 && !(ni > 0 && run == MAXB)) begin
        expOwner.push_back(2'b10);
        nd--;
        run = (ni > 0) ? ((run < MAXB) ? run + 1 : run) : 0;
      end else begin
        expOwner.push_back(2'b01);
        ni--;
        run = 0;
      end
    end
  endfunction

  // Plays the memory side and checks grants, held fields, acks and read data until both queues drain
  task automatic serve(input int stallLat);
    logic [1:0]  own = 2'b00;
    job_t        cur = '0;
    logic [31:0] rdDue = '0;
    bit          busy = 1'b0, ackDue = 1'b0, errDue = 1'b0, seenAck = 1'b0;
    int          k = 0, lat = 0, guard = 0, ackCyc = 0;
    buildOrder();
    while ((expOwner.size() > 0 || busy || ackDue) && guard < 3000) begin
      @(negedge iCLK);
      guard++;
      if (ackDue) begin
        chk("ack_i", 32'(oIAck), 32'(own == 2'b01));
        chk("ack_d", 32'(oDAck), 32'(own == 2'b10));
        chk("bus_err", 32'(oBusErr), 32'(errDue));
        if (own == 2'b01) begin
          chk("rdata_i", oIRdata, rdDue);
          lastI = rdDue;
          if (qI.size() > 0) void'(qI.pop_front());
        end else begin
          chk("rdata_d", oDRdata, rdDue);
          lastD = rdDue;
          if (qD.size() > 0) void'(qD.pop_front());
        end
        ackDue  = 1'b0;
        seenAck = 1'b1;
        ackCyc  = guard;
        present();
      end else begin
        chk("no_ack", {30'd0, oIAck, oDAck}, 32'd0);
        chk("no_err", 32'(oBusErr), 32'd0);
      end
      iMAck = 1'b0;
      if (busy || oMReq) begin
        if (!busy) begin
          busy = 1'b1;
          k    = 0;
          if (seenAck) chk("grant_gap", 32'(guard - ackCyc), 32'd2);
          if (expOwner.size() > 0) own = expOwner.pop_front();
          else own = 2'b11;
          chk("owner", 32'(oOwner), 32'(own));
          if (own == 2'b01 && qI.size() > 0) cur = qI[0];
          else if (qD.size() > 0) cur = qD[0];
          lat = (stallLat >= 0) ? stallLat : int'($urandom_range(0, 3));
        end
        chk("m_req", 32'(oMReq), 32'd1);
        chk("m_owner_hold", 32'(oOwner), 32'(own));
        chk("m_addr", oMAddr, cur.addr);
        chk("m_we", 32'(oMWe), 32'(cur.we));
        chk("m_be", 32'(oMBe), 32'(cur.be));
        chk("m_wdata", oMWdata, cur.wdata);
        if (k == lat) begin
          iMAck   = 1'b1;
          iMRdata = useForce ? forceRd : $urandom;
          rdDue   = cur.we ? ((own == 2'b01) ? lastI : lastD) : iMRdata;
          errDue  = 1'b0;
          ackDue  = 1'b1;
          busy    = 1'b0;
        end else if (TMO_ON && k == TMO - 1) begin
          rdDue  = 32'hDEADBEEF;
          errDue = 1'b1;
          ackDue = 1'b1;
          busy   = 1'b0;
        end
        k++;
      end else begin
        iMAck   = ($urandom_range(0, 3) == 0);
        iMRdata = $urandom;
      end
    end
    iMAck = 1'b0;
    chk("serve_done", 32'(guard < 3000), 32'd1);
  endtask

  initial begin
    job_t j;
    int   w;
    iRST_N = 1'b0; iMAck = 1'b0; iMRdata = '0;
    qI.delete(); qD.delete();

    // Reset held with a data request pending
    j = rndJob(); j.we = 1'b0; qD.push_back(j); present();
    repeat (3) @(negedge iCLK);
    chk("rst_mreq", 32'(oMReq), 32'd0);
    chk("rst_owner", 32'(oOwner), 32'd0);
    chk("rst_acks", {29'd0, oIAck, oDAck, oBusErr}, 32'd0);
    chk("rst_mfields", {27'd0, oMWe, oMBe}, 32'd0);
    chk("rst_maddr", oMAddr, 32'd0);
    chk("rst_mwdata", oMWdata, 32'd0);
    chk("rst_irdata", oIRdata, 32'd0);
    chk("rst_drdata", oDRdata, 32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    chk("rst_rel_edge1", 32'(oMReq), 32'd0);
    @(negedge iCLK);
    chk("rst_rel_edge2_req", 32'(oMReq), 32'd1);
    chk("rst_rel_edge2_owner", 32'(oOwner), 32'd2);
    serve(-1);

    // Single data read, memory acks in the first busy cycle
    j = '0; j.addr = 32'h1001_0004; j.be = 4'hF; qD.push_back(j); present();
    useForce = 1'b1; forceRd = 32'hCAFEF00D;
    serve(0);
    useForce = 1'b0;

    // Simultaneous requests: data byte-write first, then instruction read
    j = rndJob(); j.we = 1'b1; j.be = 4'b0011; qD.push_back(j);
    j = rndJob(); j.we = 1'b0; qI.push_back(j);
    present();
    serve(-1);

    // Starvation guard with instruction held and data re-requesting
    for (int n = 0; n < 2; n++) qI.push_back(rndJob());
    for (int n = 0; n < 9; n++) qD.push_back(rndJob());
    present();
    serve(-1);

    // Memory stalls for 20 cycles on each transfer
    j = rndJob(); j.we = 1'b0; qD.push_back(j);
    j = rndJob(); j.we = 1'b0; qI.push_back(j);
    present();
    serve(20);

    // Randomized mixes
    for (int r = 0; r < 8; r++) begin
      int ni = $urandom_range(0, 5);
      int nd = $urandom_range(0, 8);
      for (int n = 0; n < ni; n++) qI.push_back(rndJob());
      for (int n = 0; n < nd; n++) qD.push_back(rndJob());
      present();
      serve(-1);
    end

    // Reset in the middle of a transfer abandons it
    qD.push_back(rndJob()); present();
    w = 0;
    while (!oMReq && w < 50) begin
      @(negedge iCLK);
      w++;
    end
    chk("midrst_grant", 32'(oMReq), 32'd1);
    iRST_N = 1'b0;
    #1;
    chk("midrst_req", 32'(oMReq), 32'd0);
    chk("midrst_owner", 32'(oOwner), 32'd0);
    qD.delete(); qI.delete(); present();
    lastI = '0; lastD = '0;
    repeat (2) begin
      @(negedge iCLK);
      chk("midrst_noack", {30'd0, oIAck, oDAck}, 32'd0);
    end
    iRST_N = 1'b1;
    for (int n = 0; n < 4; n++) qI.push_back(rndJob());
    for (int n = 0; n < 6; n++) qD.push_back(rndJob());
    present();
    serve(-1);

    repeat (2) @(negedge iCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified memory port between the CPU instruction-fetch bus and the data bus.
- Needed by the multicycle and bootloader builds, where code and data live in the same physical RAM.
- Arbitrates with fixed data-first priority and an instruction anti-starvation guard.
- Registers the winning request onto the memory port and returns the read data and ack to the winner only.

Parameters:
- MAX_D_BURST, 4: consecutive data grants allowed while an instruction request is pending.
- TIMEOUT, 255: memory-ack timeout in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iIReq  in  1  instruction-bus request.
- iIWe  in  1  instruction-bus write (bootloader code write).
- iIBe  in  4  instruction-bus byte enables.
- iIAddr  in  32  instruction-bus address.
- iIWdata  in  32  instruction-bus write data.
- oIAck  out  1  instruction transfer complete, one-cycle pulse.
- oIRdata  out  32  instruction read data, valid while oIAck=1.
- iDReq, iDWe, iDBe[3:0], iDAddr[31:0], iDWdata[31:0]  in  data-bus equivalents of the instruction inputs.
- oDAck  out  1  data transfer complete, one-cycle pulse.
- oDRdata  out  32  data read data, valid while oDAck=1.
- oMReq  out  1  memory request.
- oMWe  out  1  memory write.
- oMBe  out  4  memory byte enables.
- oMAddr  out  32  memory address.
- oMWdata  out  32  memory write data.
- iMAck  in  1  memory completion, one-cycle pulse.
- iMRdata  in  32  memory read data, valid while iMAck=1.
- oOwner  out  2  current owner: 00 none, 01 instruction, 10 data.
- oBusErr  out  1  timeout error, pulses together with the ack.

Behaviour:
- Reset: asynchronous on iRST_N=0, released synchronously to iCLK.
  - All outputs 0, state IDLE, burst counter 0, timeout counter 0.
  - Reset mid-transaction abandons the transfer: oMReq falls immediately and no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Samples iIReq and iDReq each cycle.
  - Only one requesting: grant it.
  - Both requesting: grant D, unless burst counter = MAX_D_BURST, then grant I.
  - On grant, register We/Be/Addr/Wdata of the winner onto oM*, set oOwner, go BUSY. oMReq=1 from the next cycle (1-cycle grant latency).
  - No request: stay IDLE with oMReq=0.
- BUSY:
  - oMReq and all oM* fields held stable until iMAck=1.
  - On iMAck: latch iMRdata into the owner's Rdata register, go RESP, drop oMReq.
- RESP (exactly one cycle):
  - Owner's Ack=1 and owner's Rdata valid. The non-owner's Ack stays 0.
  - Next state IDLE, oOwner=00.
  - Ack therefore appears 1 cycle after iMAck.
  - Minimum transfer is 3 cycles (IDLE → BUSY with iMAck in its first cycle → RESP).
- Requester rules:
  - Hold Req and all fields stable from assertion until its Ack.
  - Deassert Req, or present a new request, in the cycle after Ack.
  - Req dropped before Ack is undefined usage; the arbiter completes the latched transfer regardless.
- Burst counter:
  - Increments on each D grant made while iIReq=1, saturating at MAX_D_BURST.
  - Clears on any I grant.
  - Clears in IDLE whenever iIReq=0.
- Rdata registers: hold their last value outside Ack. Write transfers leave Rdata unchanged.
- iMAck outside BUSY is ignored.
- Without ARB_TIMEOUT_EN, oBusErr is constant 0 and BUSY waits indefinitely.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to BUSY and increments each BUSY cycle without iMAck.
  - When the count reaches TIMEOUT: go RESP, drop oMReq, owner's Rdata = 32'hDEADBEEF, oBusErr=1 for the RESP cycle.
  - A late iMAck arriving after the timeout is ignored.
- Undefined: the counter and its logic are absent, and oBusErr is tied 0.

Test Plan:
- Reset: hold iRST_N=0 while iDReq=1 → all outputs 0. Release → oMReq=1 exactly 2 edges later with oOwner=10.
- Single data read: iDReq=1, iDAddr=0x10010004; iMAck asserted at the first BUSY cycle with iMRdata=0xCAFEF00D → oMAddr=0x10010004, then oDAck=1 with oDRdata=0xCAFEF00D one cycle later; oIAck stays 0.
- Simultaneous requests, one each: iIReq=iDReq=1 → D served first, then I. Byte-enable write iDBe=4'b0011 appears on oMBe unchanged.
- Starvation guard (MAX_D_BURST=4): iIReq held high while iDReq is re-asserted after every ack → grant order D,D,D,D,I,D…
- Stall memory: iMAck held low for 20 cycles → oM* stable for all 20 cycles; no ack until iMAck, then ack on the next cycle.
- ARB_TIMEOUT_EN with TIMEOUT=8 and iMAck never asserted → 8 BUSY cycles, then oDAck=1, oBusErr=1, oDRdata=0xDEADBEEF. A later stray iMAck has no effect.
